// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - shared widths and controller state encoding for the DES block-chaining path
package des_pkg;
  localparam int DES_BLK_W = 64;
  localparam int DES_KEY_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_OUT   = 2'd3
  } des_state_t;
endpackage

// File: rtl/des_cbc_ctrl_if.sv
// rtl/des_cbc_ctrl_if.sv - plaintext-in / ciphertext-out block streams of the chaining controller
interface des_cbc_ctrl_if;
  import des_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [DES_BLK_W-1:0] in_data;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [DES_BLK_W-1:0] out_data;
  logic                 out_last;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/des_cbc_ctrl.sv
// rtl/des_cbc_ctrl.sv - CBC/ECB block former feeding the DES core, one block in flight
module des_cbc_ctrl
  import des_pkg::*;
#(
  parameter bit CBC_EN  = 1'b1,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  des_cbc_ctrl_if.slave        strm,
  input  logic [DES_KEY_W-1:0] key_din,
  input  logic [DES_BLK_W-1:0] iv_din,
  input  logic                 iv_load,
  output logic [DES_BLK_W-1:0] des_plain,
  output logic [DES_KEY_W-1:0] des_key,
  output logic                 des_start,
  input  logic [DES_BLK_W-1:0] des_cipher,
  input  logic                 des_valid,
  output logic                 busy,
  output logic                 err
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  des_state_t           state_q, state_d;
  logic                 init_q;
  logic [DES_BLK_W-1:0] chain_q, iv_q, plain_q, out_data_q;
  logic [DES_KEY_W-1:0] key_q;
  logic                 last_q, out_last_q, dv_q, err_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 in_ready_c, accept, capture, timed_out;
  logic [DES_BLK_W-1:0] chain_src;

  assign accept    = in_ready_c & strm.in_valid;
  assign capture   = des_valid & ~dv_q;
  assign timed_out = (cnt_q == CNT_W'(TIMEOUT));
  // A coinciding iv_load must already chain the block being accepted.
  assign chain_src = iv_load ? iv_din : chain_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (timed_out)    state_d = ST_IDLE;
        else if (capture) state_d = ST_OUT;
      end
      ST_OUT:   if (strm.out_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready_c     = (state_q == ST_IDLE) & init_q;
    des_start      = (state_q == ST_ISSUE);
    strm.out_valid = (state_q == ST_OUT);
    busy           = (state_q != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_q     <= 1'b0;
      chain_q    <= '0;
      iv_q       <= '0;
      plain_q    <= '0;
      key_q      <= '0;
      out_data_q <= '0;
      last_q     <= 1'b0;
      out_last_q <= 1'b0;
      dv_q       <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      init_q <= 1'b1;
      dv_q   <= des_valid;
      case (state_q)
        ST_IDLE: begin
          if (iv_load) begin
            iv_q    <= iv_din;
            chain_q <= iv_din;
          end
          if (accept) begin
            plain_q <= CBC_EN ? (strm.in_data ^ chain_src) : strm.in_data;
            key_q   <= key_din;
            last_q  <= strm.in_last;
          end
        end
        ST_ISSUE: cnt_q <= '0;
        ST_WAIT: begin
          if (!timed_out) begin
            cnt_q <= cnt_q + 1'b1;
            if (capture) begin
              out_data_q <= des_cipher;
              chain_q    <= des_cipher;
              out_last_q <= last_q;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
              err_q <= 1'b1;
            end
          end
        end
        ST_OUT: begin
          // End of message: the next block restarts chaining from the IV.
          if (strm.out_ready && last_q) chain_q <= iv_q;
        end
        default: ;
      endcase
    end
  end

  assign strm.in_ready = in_ready_c;
  assign strm.out_data = out_data_q;
  assign strm.out_last = out_last_q;
  assign des_plain     = plain_q;
  assign des_key       = key_q;
  assign err           = err_q;
endmodule

// File: tb/tb_des_cbc_ctrl.sv
// tb/tb_des_cbc_ctrl.sv - directed vector bench for des_cbc_ctrl in CBC and ECB configurations
module tb_des_cbc_ctrl;
  import des_pkg::*;

  localparam logic [63:0] KEY = 64'h133457799BBCDFF1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  des_cbc_ctrl_if c_if ();
  des_cbc_ctrl_if e_if ();

  logic [63:0] c_key, c_iv, c_plain, c_dkey, c_cipher;
  logic        c_iv_load, c_start, c_valid, c_busy, c_err;
  logic [63:0] e_key, e_iv, e_plain, e_dkey, e_cipher;
  logic        e_iv_load, e_start, e_valid, e_busy, e_err;

  logic        stub_en, stub_valid, man_valid;
  logic [63:0] stub_cipher, man_cipher;
  assign c_valid  = stub_en ? stub_valid  : man_valid;
  assign c_cipher = stub_en ? stub_cipher : man_cipher;

  des_cbc_ctrl #(.CBC_EN(1'b1), .TIMEOUT(8)) u_cbc (
    .clk(clk), .rst_n(rst_n), .strm(c_if),
    .key_din(c_key), .iv_din(c_iv), .iv_load(c_iv_load),
    .des_plain(c_plain), .des_key(c_dkey), .des_start(c_start),
    .des_cipher(c_cipher), .des_valid(c_valid), .busy(c_busy), .err(c_err)
  );

  des_cbc_ctrl #(.CBC_EN(1'b0), .TIMEOUT(8)) u_ecb (
    .clk(clk), .rst_n(rst_n), .strm(e_if),
    .key_din(e_key), .iv_din(e_iv), .iv_load(e_iv_load),
    .des_plain(e_plain), .des_key(e_dkey), .des_start(e_start),
    .des_cipher(e_cipher), .des_valid(e_valid), .busy(e_busy), .err(e_err)
  );

  typedef struct {
    logic [63:0] data;
    logic        last;
    logic        iv_load;
    logic [63:0] iv;
    logic [63:0] key;
    logic [63:0] exp_plain;
    logic [63:0] exp_out;
    int          stall;
  } vec_t;

  vec_t vecs[6];
  int checks = 0;
  int errors = 0;

  // Core stand-in: the one known DES answer, otherwise plain ^ key.
  function automatic logic [63:0] fake_des(input logic [63:0] p, input logic [63:0] k);
    if (p == 64'h0123456789ABCDEF && k == KEY) return 64'h85E813540F0AB405;
    return p ^ k;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (stub_en && c_start) begin
      stub_cipher = fake_des(c_plain, c_dkey);
      repeat (2) @(negedge clk);
      stub_valid = 1'b1;
      repeat (2) @(negedge clk);
      stub_valid = 1'b0;
    end
  end

  task automatic run_vec(input vec_t v);
    int k;
    @(negedge clk);
    chk("idle_in_ready", 64'(c_if.in_ready), 64'd1);
    c_if.in_valid = 1'b1;
    c_if.in_data  = v.data;
    c_if.in_last  = v.last;
    c_key         = v.key;
    c_iv_load     = v.iv_load;
    c_iv          = v.iv;
    @(negedge clk);
    c_if.in_valid = 1'b0;
    c_iv_load     = 1'b0;
    c_if.in_data  = ~v.data;
    c_key         = ~v.key;
    chk("start_pulse", 64'(c_start), 64'd1);
    chk("des_plain", c_plain, v.exp_plain);
    chk("des_key", c_dkey, v.key);
    chk("busy_in_ready", 64'(c_if.in_ready), 64'd0);
    @(negedge clk);
    chk("start_one_cycle", 64'(c_start), 64'd0);
    k = 1;
    while (!c_if.out_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("out_latency", 64'(k), 64'd3);
    chk("out_data", c_if.out_data, v.exp_out);
    chk("out_last", 64'(c_if.out_last), 64'(v.last));
    chk("plain_held", c_plain, v.exp_plain);
    for (int s = 0; s < v.stall; s++) begin
      @(negedge clk);
      chk("stall_valid", 64'(c_if.out_valid), 64'd1);
      chk("stall_data", c_if.out_data, v.exp_out);
      chk("stall_last", 64'(c_if.out_last), 64'(v.last));
      chk("stall_in_ready", 64'(c_if.in_ready), 64'd0);
      chk("stall_busy", 64'(c_busy), 64'd1);
    end
    c_if.out_ready = 1'b1;
    @(negedge clk);
    c_if.out_ready = 1'b0;
    chk("post_out_valid", 64'(c_if.out_valid), 64'd0);
    chk("post_in_ready", 64'(c_if.in_ready), 64'd1);
    chk("post_busy", 64'(c_busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int k;
    vecs[0] = '{64'h0123456789ABCDEF, 1'b0, 1'b0, 64'h0, KEY,
                64'h0123456789ABCDEF, 64'h85E813540F0AB405, 0};
    vecs[1] = '{64'h0123456789ABCDEF, 1'b1, 1'b0, 64'h0, KEY,
                64'h84CB563386A179EA, 64'h97FF014A1D1DA61B, 10};
    vecs[2] = '{64'h0123456789ABCDEF, 1'b0, 1'b0, 64'h0, KEY,
                64'h0123456789ABCDEF, 64'h85E813540F0AB405, 0};
    vecs[3] = '{64'h0000000000000000, 1'b1, 1'b1, 64'hFFFFFFFFFFFFFFFF, KEY,
                64'hFFFFFFFFFFFFFFFF, 64'hECCBA8866443200E, 0};
    vecs[4] = '{64'h0123456789ABCDEF, 1'b0, 1'b0, 64'h0, KEY,
                64'hFEDCBA9876543210, 64'hEDE8EDE1EDE8EDE1, 0};
    vecs[5] = '{64'hEDE8EDE1EDE8EDE1, 1'b1, 1'b0, 64'h0, 64'hFFFFFFFF00000000,
                64'h0000000000000000, 64'hFFFFFFFF00000000, 0};

    c_if.in_valid = 1'b0; c_if.in_data = '0; c_if.in_last = 1'b0; c_if.out_ready = 1'b0;
    e_if.in_valid = 1'b0; e_if.in_data = '0; e_if.in_last = 1'b0; e_if.out_ready = 1'b0;
    c_key = '0; c_iv = '0; c_iv_load = 1'b0;
    e_key = '0; e_iv = '0; e_iv_load = 1'b0; e_cipher = '0; e_valid = 1'b0;
    stub_en = 1'b1; stub_valid = 1'b0; stub_cipher = '0;
    man_valid = 1'b0; man_cipher = 64'hDEADBEEFCAFEF00D;

    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(c_if.in_ready), 64'd0);
    chk("rst_out_valid", 64'(c_if.out_valid), 64'd0);
    chk("rst_busy", 64'(c_busy), 64'd0);
    chk("rst_err", 64'(c_err), 64'd0);
    chk("rst_start", 64'(c_start), 64'd0);
    chk("rst_plain", c_plain, 64'd0);
    chk("rst_out_data", c_if.out_data, 64'd0);
    rst_n = 1'b1;
    chk("rel_in_ready_low", 64'(c_if.in_ready), 64'd0);
    @(negedge clk);
    chk("rel_in_ready_high", 64'(c_if.in_ready), 64'd1);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Core never answers: block dropped, chain must still hold the last ciphertext.
    stub_en = 1'b0;
    @(negedge clk);
    c_if.in_valid = 1'b1; c_if.in_data = 64'h1111111111111111; c_if.in_last = 1'b0; c_key = KEY;
    @(negedge clk);
    c_if.in_valid = 1'b0;
    chk("to_start", 64'(c_start), 64'd1);
    repeat (8) @(negedge clk);
    chk("to_err_early", 64'(c_err), 64'd0);
    @(negedge clk);
    chk("to_err", 64'(c_err), 64'd1);
    chk("to_still_busy", 64'(c_if.in_ready), 64'd0);
    @(negedge clk);
    chk("to_in_ready", 64'(c_if.in_ready), 64'd1);
    chk("to_no_out", 64'(c_if.out_valid), 64'd0);
    stub_en = 1'b1;
    run_vec(vecs[5]);
    chk("err_sticky", 64'(c_err), 64'd1);

    // Reset in the middle of WAIT, then a late core completion.
    stub_en = 1'b0;
    @(negedge clk);
    c_if.in_valid = 1'b1; c_if.in_data = 64'h2222222222222222; c_key = KEY;
    @(negedge clk);
    c_if.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 64'(c_if.in_ready), 64'd0);
    chk("mid_rst_busy", 64'(c_busy), 64'd0);
    chk("mid_rst_err", 64'(c_err), 64'd0);
    chk("mid_rst_plain", c_plain, 64'd0);
    chk("mid_rst_key", c_dkey, 64'd0);
    chk("mid_rst_out_data", c_if.out_data, 64'd0);
    chk("mid_rst_out_last", 64'(c_if.out_last), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    man_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("late_valid_ignored", 64'(c_if.out_valid), 64'd0);
    end
    man_valid = 1'b0;
    chk("late_in_ready", 64'(c_if.in_ready), 64'd1);

    // ECB: a prior IV load must not alter the core input.
    @(negedge clk);
    e_iv_load = 1'b1; e_iv = 64'hFFFFFFFFFFFFFFFF;
    @(negedge clk);
    e_iv_load = 1'b0;
    e_if.in_valid = 1'b1; e_if.in_data = 64'h0123456789ABCDEF; e_if.in_last = 1'b1; e_key = KEY;
    @(negedge clk);
    e_if.in_valid = 1'b0;
    chk("ecb_start", 64'(e_start), 64'd1);
    chk("ecb_plain", e_plain, 64'h0123456789ABCDEF);
    chk("ecb_key", e_dkey, KEY);
    @(negedge clk);
    e_cipher = 64'h85E813540F0AB405; e_valid = 1'b1;
    k = 0;
    while (!e_if.out_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("ecb_latency", 64'(k), 64'd1);
    chk("ecb_out_data", e_if.out_data, 64'h85E813540F0AB405);
    chk("ecb_out_last", 64'(e_if.out_last), 64'd1);
    e_if.out_ready = 1'b1;
    @(negedge clk);
    e_if.out_ready = 1'b0; e_valid = 1'b0;
    chk("ecb_done", 64'(e_if.in_ready), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/des_cbc_ctrl.md
# des_cbc_ctrl

Upstream block-chaining controller for the DES core (`DES_top`). It accepts a stream of 64-bit plaintext blocks over a valid/ready handshake and forms each core input block, in CBC (XOR with IV / previous ciphertext) or ECB mode. It drives the core's `plain_text` / `key_din` / `start`, captures `cipher_text` on `dat_valid`, and presents the result downstream over valid/ready. One block is in flight at a time.

## Interface
- `CBC_EN`, default 1: 1 = CBC chaining, 0 = ECB (no XOR).
- `TIMEOUT`, default 64: maximum WAIT cycles for the core's `des_valid` rising edge before the block is abandoned.
- `clk` in 1: single clock, all logic rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `key_din` in 64: DES key, sampled at block accept.
- `iv_din` in 64: initialisation vector.
- `iv_load` in 1: loads `iv_din` into IV and chain registers; honoured in IDLE only.
- `in_valid` in 1 / `in_ready` out 1 / `in_data` in 64 / `in_last` in 1: plaintext block stream; `in_last` marks the final block of a message.
- `out_valid` out 1 / `out_ready` in 1 / `out_data` out 64 / `out_last` out 1: ciphertext stream.
- `des_plain` out 64: to core `plain_text`.
- `des_key` out 64: to core `key_din`.
- `des_start` out 1: to core `start`.
- `des_cipher` in 64: from core `cipher_text`.
- `des_valid` in 1: from core `dat_valid`.
- `busy` out 1: high in any state other than IDLE.
- `err` out 1: sticky timeout flag; cleared only by reset.

## Operation
- States: IDLE, ISSUE, WAIT, OUT.
- IDLE:
  - `in_ready` = 1.
  - On `in_valid`: latch `des_plain` = `in_data ^ chain` (CBC) or `in_data` (ECB), `des_key` = `key_din`, and `last_q` = `in_last`; go to ISSUE.
- `iv_load` in IDLE: IV and chain ← `iv_din`.
  - If it coincides with an accept, the block uses the new IV: `des_plain` = `in_data ^ iv_din`.
  - `iv_load` in any other state is ignored.
- ISSUE:
  - `des_start` = 1 for exactly one cycle; timeout counter cleared.
  - Go to WAIT.
- WAIT:
  - Capture on `des_valid & ~des_valid_q` (rising edge, registered `des_valid_q`). A level that is already high on entry is not a completion.
  - On capture: `out_data` ← `des_cipher`, chain ← `des_cipher`, `out_last` ← `last_q`; go to OUT.
  - The counter increments every WAIT cycle. When it reaches `TIMEOUT` with no edge: `err` ← 1, the block is dropped, chain is unchanged, go to IDLE.
- OUT:
  - `out_valid` = 1; `out_data` and `out_last` are held stable until `out_ready`.
  - On `out_ready`: go to IDLE. If `last_q`, chain ← IV register, so the next message restarts from the IV.
- `des_plain` and `des_key` stay constant from accept until the next accept.
- Reset (any state, including mid-WAIT):
  - Returns to IDLE.
  - Any in-flight block is discarded.
  - All registers are cleared.

## Timing
- Reset values:
  - `in_ready` = 0 while `rst_n` is low, 1 from the first cycle after release.
  - `out_valid`, `out_last`, `des_start`, `busy`, `err` = 0.
  - `out_data`, `des_plain`, `des_key`, chain, IV = 0.
- Accept happens at edge N (IDLE with `in_valid`).
  - `des_start` is high in cycle N+1.
  - WAIT begins at N+2.
- A `des_valid` rising edge sampled at edge M gives `out_valid` = 1 from cycle M+1.
- Minimum accept → `out_valid` latency: 3 cycles plus core latency.
- Throughput: the next accept is possible no earlier than the cycle after the `out_valid & out_ready` handshake.
- Timeout: `err` rises at exactly `TIMEOUT` cycles after WAIT entry; IDLE follows in the next cycle.

## Structure
- Shared package `des_pkg`: `DES_BLK_W` = 64, `DES_KEY_W` = 64, and the state enum/localparams (`ST_IDLE`, `ST_ISSUE`, `ST_WAIT`, `ST_OUT`).
- No sub-module. The timeout counter is inline, with width `$clog2(TIMEOUT+1)`.
- `DES_top` is instantiated beside this block at the integration level, not inside it.

## Test plan
- ECB (`CBC_EN`=0), key 133457799BBCDFF1, block 0123456789ABCDEF → `des_plain` = 0123456789ABCDEF, `out_data` = 85E813540F0AB405.
- CBC, IV 0, two blocks of 0123456789ABCDEF:
  - Block 2 `des_plain` = 84CB563386A179EA.
  - With `in_last` on block 2, a third block after it uses IV 0 again (`des_plain` = 0123456789ABCDEF).
- `out_ready` held low 10 cycles → `out_data` and `out_last` stable, `in_ready` = 0, `busy` = 1 throughout.
- Core stub that never raises `des_valid`, `TIMEOUT` = 8 → `err` = 1 eight cycles after WAIT entry; `in_ready` = 1 the next cycle; chain unchanged.
- `iv_load` with `iv_din` = FFFFFFFFFFFFFFFF in the same cycle as accept of 0000000000000000 → `des_plain` = FFFFFFFFFFFFFFFF.
- `rst_n` pulsed low during WAIT → all outputs 0 immediately; a later core `des_valid` edge produces no `out_valid`.
